// File: rtl/flash_audio_reader.sv
// Reads one 32-bit word from flash and plays it as two signed 16-bit samples,
// low half first, one sample per audio-rate strobe.
module flash_audio_reader (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_flash,
    input  logic [31:0]        byte_address,
    input  logic               sample_clk_en,
    input  logic               flash_mem_waitrequest,
    input  logic [31:0]        flash_mem_readdata,
    input  logic               flash_mem_readdatavalid,
    output logic               flash_mem_read,
    output logic [22:0]        flash_mem_address,
    output logic [3:0]         flash_mem_byteenable,
    output logic signed [15:0] audio_data,
    output logic               audio_done,
    output logic               read_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DATA,
        S_WAIT_S0,
        S_WAIT_S1,
        S_DONE
    } state_t;

    // Watchdog value whose increment lands on 255, i.e. the last cycle before giving up.
    localparam logic [7:0] WDOG_LAST = 8'd254;

    state_t             state_q, state_d;
    logic [22:0]        addr_q, addr_d;
    logic [31:0]        word_q, word_d;
    logic signed [15:0] audio_q, audio_d;
    logic [7:0]         wdog_q, wdog_d;
    logic               err_q, err_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{byte_address[31:25], byte_address[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            audio_q <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            audio_q <= audio_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        audio_d = audio_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_flash) begin
                    addr_d  = byte_address[24:2];
                    wdog_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                wdog_d = wdog_q + 8'd1;
                if (wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    word_d  = '0;
                    state_d = S_WAIT_S0;
                end else if (!flash_mem_waitrequest) begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                wdog_d = wdog_q + 8'd1;
                // Data arriving on the final watchdog cycle is still taken.
                if (flash_mem_readdatavalid) begin
                    word_d  = flash_mem_readdata;
                    state_d = S_WAIT_S0;
                end else if (wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    word_d  = '0;
                    state_d = S_WAIT_S0;
                end
            end
            S_WAIT_S0: begin
                if (sample_clk_en) begin
                    audio_d = $signed(word_q[15:0]);
                    state_d = S_WAIT_S1;
                end
            end
            S_WAIT_S1: begin
                if (sample_clk_en) begin
                    audio_d = $signed(word_q[31:16]);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign flash_mem_read       = (state_q == S_REQ);
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = 4'hF;
    assign audio_data           = audio_q;
    assign audio_done           = (state_q == S_DONE);
    assign read_error           = err_q;

endmodule

// File: tb/tb_flash_audio_reader.sv
// Directed bench for flash_audio_reader: a table of read transactions plus
// hand-written retrigger, timeout and mid-playback reset sequences.
module tb_flash_audio_reader;

    logic               clk = 1'b0;
    logic               reset;
    logic               start_flash;
    logic [31:0]        byte_address;
    logic               sample_clk_en;
    logic               flash_mem_waitrequest;
    logic [31:0]        flash_mem_readdata;
    logic               flash_mem_readdatavalid;
    logic               flash_mem_read;
    logic [22:0]        flash_mem_address;
    logic [3:0]         flash_mem_byteenable;
    logic signed [15:0] audio_data;
    logic               audio_done;
    logic               read_error;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_audio = 16'h0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          wc;
        int          vd;
        logic        early;
        logic [22:0] exp_addr;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } txn_t;

    txn_t tbl [4];

    flash_audio_reader dut (
        .clk                     (clk),
        .reset                   (reset),
        .start_flash             (start_flash),
        .byte_address            (byte_address),
        .sample_clk_en           (sample_clk_en),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .audio_data              (audio_data),
        .audio_done              (audio_done),
        .read_error              (read_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input txn_t t);
        chk("idle_read", 32'(flash_mem_read), 32'd0);
        byte_address          = t.addr;
        start_flash           = 1'b1;
        flash_mem_waitrequest = (t.wc != 0);
        tick();
        start_flash  = 1'b0;
        byte_address = ~t.addr;
        for (int i = 0; i <= t.wc; i++) begin
            flash_mem_waitrequest = (i < t.wc);
            sample_clk_en         = t.early;
            chk("req_read", 32'(flash_mem_read), 32'd1);
            chk("req_addr", {9'd0, flash_mem_address}, {9'd0, t.exp_addr});
            tick();
        end
        flash_mem_waitrequest = 1'b0;
        chk("read_drop", 32'(flash_mem_read), 32'd0);
        for (int j = 1; j < t.vd; j++) tick();
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = t.data;
        tick();
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'hDEAD_DEAD;
        sample_clk_en           = 1'b0;
        chk("audio_hold_arrival", {16'd0, audio_data}, {16'd0, exp_audio});
        tick();
        chk("audio_hold_s0", {16'd0, audio_data}, {16'd0, exp_audio});
        sample_clk_en = 1'b1;
        tick();
        sample_clk_en = 1'b0;
        chk("audio_lo", {16'd0, audio_data}, {16'd0, t.exp_lo});
        chk("done_after_s1", 32'(audio_done), 32'd0);
        tick();
        tick();
        chk("audio_lo_hold", {16'd0, audio_data}, {16'd0, t.exp_lo});
        sample_clk_en = 1'b1;
        tick();
        sample_clk_en = 1'b0;
        chk("audio_hi", {16'd0, audio_data}, {16'd0, t.exp_hi});
        chk("done_pulse", 32'(audio_done), 32'd1);
        tick();
        chk("done_clear", 32'(audio_done), 32'd0);
        exp_audio = t.exp_hi;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        tbl[0] = '{32'h0000_1004, 32'hBEEF_1234, 0, 2, 1'b0, 23'h000401, 16'h1234, 16'hBEEF};
        tbl[1] = '{32'h01FF_FFFF, 32'h8000_7FFF, 5, 1, 1'b1, 23'h7FFFFF, 16'h7FFF, 16'h8000};
        tbl[2] = '{32'hFE00_0003, 32'h0000_FFFF, 2, 3, 1'b0, 23'h000000, 16'hFFFF, 16'h0000};
        tbl[3] = '{32'h0123_4568, 32'h5A5A_A5A5, 1, 4, 1'b1, 23'h48D15A, 16'hA5A5, 16'h5A5A};

        reset                   = 1'b1;
        start_flash             = 1'b0;
        byte_address            = 32'h0;
        sample_clk_en           = 1'b0;
        flash_mem_waitrequest   = 1'b0;
        flash_mem_readdata      = 32'h0;
        flash_mem_readdatavalid = 1'b0;
        #1;
        chk("rst_read", 32'(flash_mem_read), 32'd0);
        chk("rst_addr", {9'd0, flash_mem_address}, 32'd0);
        chk("rst_audio", {16'd0, audio_data}, 32'd0);
        chk("rst_done", 32'(audio_done), 32'd0);
        chk("rst_err", 32'(read_error), 32'd0);
        chk("byteenable", {28'd0, flash_mem_byteenable}, 32'hF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) run_txn(tbl[k]);

        // Held start_flash retriggers straight after DONE.
        byte_address = 32'h0000_0100;
        start_flash  = 1'b1;
        tick();
        chk("rt_read", 32'(flash_mem_read), 32'd1);
        chk("rt_addr", {9'd0, flash_mem_address}, 32'h40);
        tick();
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'hCAFE_F00D;
        tick();
        flash_mem_readdatavalid = 1'b0;
        sample_clk_en = 1'b1;
        tick();
        chk("rt_lo", {16'd0, audio_data}, 32'h0000_F00D);
        tick();
        sample_clk_en = 1'b0;
        chk("rt_hi", {16'd0, audio_data}, 32'h0000_CAFE);
        chk("rt_done", 32'(audio_done), 32'd1);
        tick();
        chk("rt_idle_read", 32'(flash_mem_read), 32'd0);
        tick();
        chk("rt_retrigger", 32'(flash_mem_read), 32'd1);
        start_flash = 1'b0;
        tick();
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'h1357_2468;
        tick();
        flash_mem_readdatavalid = 1'b0;
        sample_clk_en = 1'b1;
        tick();
        tick();
        sample_clk_en = 1'b0;
        chk("rt2_hi", {16'd0, audio_data}, 32'h0000_1357);
        chk("rt2_done", 32'(audio_done), 32'd1);
        tick();
        exp_audio = 16'h1357;

        // No data ever returns: watchdog fires and silence is played.
        byte_address = 32'h0000_0040;
        start_flash  = 1'b1;
        tick();
        start_flash = 1'b0;
        n = 0;
        while (read_error !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("wdog_cycles", 32'(n), 32'd255);
        chk("to_err", 32'(read_error), 32'd1);
        chk("to_read", 32'(flash_mem_read), 32'd0);
        chk("to_audio_hold", {16'd0, audio_data}, {16'd0, exp_audio});
        sample_clk_en = 1'b1;
        tick();
        sample_clk_en = 1'b0;
        chk("to_s0_silence", {16'd0, audio_data}, 32'd0);
        chk("to_s0_done", 32'(audio_done), 32'd0);
        tick();
        sample_clk_en = 1'b1;
        tick();
        sample_clk_en = 1'b0;
        chk("to_s1_silence", {16'd0, audio_data}, 32'd0);
        chk("to_done", 32'(audio_done), 32'd1);
        tick();
        chk("to_done_clear", 32'(audio_done), 32'd0);
        chk("to_err_sticky", 32'(read_error), 32'd1);

        // Reset asserted between the two samples aborts without a done pulse.
        byte_address = 32'h0000_2000;
        start_flash  = 1'b1;
        tick();
        start_flash = 1'b0;
        tick();
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'h1111_2222;
        tick();
        flash_mem_readdatavalid = 1'b0;
        sample_clk_en = 1'b1;
        tick();
        sample_clk_en = 1'b0;
        chk("rs_lo", {16'd0, audio_data}, 32'h0000_2222);
        #3;
        reset = 1'b1;
        #1;
        chk("rs_audio", {16'd0, audio_data}, 32'd0);
        chk("rs_err", 32'(read_error), 32'd0);
        chk("rs_addr", {9'd0, flash_mem_address}, 32'd0);
        chk("rs_done", 32'(audio_done), 32'd0);
        chk("rs_read", 32'(flash_mem_read), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sample_clk_en = 1'b1;
        tick();
        sample_clk_en = 1'b0;
        chk("rs_after_audio", {16'd0, audio_data}, 32'd0);
        chk("rs_after_done", 32'(audio_done), 32'd0);
        chk("rs_after_read", 32'(flash_mem_read), 32'd0);
        exp_audio = 16'h0000;
        run_txn(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
